pcie_switch_core_p: RTL
=======================

Name: pcie_switch_core_p

Overview:
- Parametrised single-clock successor of the 4-channel PCIe-style switch.
- Ingress words are steered by class field into NUM_CH virtual-channel (VC) FIFOs.
- A selectable round-robin / strict-priority arbiter moves VC head words into NUM_CH egress FIFOs by dest field, with threshold-based backpressure.
- Contains the threshold config FSM and per-egress pop counters readable in IDLE.

Parameters:
- DATA_W, 12, word width; class = data[DATA_W-1 -: CH_W], dest = data[DATA_W-1-CH_W -: CH_W].
- CH_LOG2, 2, log2 of channel count; NUM_CH = 2**CH_LOG2, CH_W = CH_LOG2.
- DEPTH_LOG2, 3, log2 of every internal FIFO depth; DEPTH = 2**DEPTH_LOG2.
- THR_W, 8, threshold input width.
- CNT_W, 8, pop counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- init  in  1  enter/stay in INIT and load thresholds.
- umbral_L  in  THR_W  almost-empty threshold.
- umbral_H  in  THR_W  almost-full threshold.
- arb_mode  in  1  0 = round-robin, 1 = strict priority (VC0 highest).
- push_in  in  1  ingress write strobe.
- data_in  in  DATA_W  ingress word.
- in_ready  out  1  combinational: target VC (by data_in class) not full.
- pop_out  in  NUM_CH  egress read strobes.
- data_out  out  NUM_CH*DATA_W  egress heads, first-word-fall-through; channel i at [i*DATA_W +: DATA_W].
- empty_out  out  NUM_CH  egress empty flags.
- almost_empty_out  out  NUM_CH  egress count <= thr_L.
- almost_full_vc  out  NUM_CH  VC count >= thr_H.
- req  in  1  counter read request.
- idx  in  CH_W+1  counter index.
- cnt_data  out  CNT_W  counter value.
- cnt_valid  out  1  cnt_data valid.
- idle  out  1  FSM in IDLE.
- error  out  2  sticky: [0] ingress overflow drop, [1] egress pop on empty.

Behaviour:
- Reset values:
  - all FIFO pointers and counts 0.
  - empty_out all 1, almost_empty_out all 1, almost_full_vc 0, data_out 0.
  - rr_ptr 0, counters 0, cnt_data 0, cnt_valid 0, error 0.
  - thr_L = 1, thr_H = DEPTH-2, state RST.
- FIFOs:
  - count width DEPTH_LOG2+1; pointers wrap modulo DEPTH.
  - Simultaneous push+pop on a non-empty FIFO keeps count unchanged and is legal when full.
- Thresholds: loaded value = min(umbral_x, DEPTH-1); thr_H = 0 is treated as 1.
- FSM states RST, INIT, IDLE, ACTIVE:
  - RST -> INIT on the first cycle without reset.
  - INIT: latch thresholds every cycle; go to IDLE when init = 0.
  - IDLE <-> ACTIVE: ACTIVE iff any VC or egress FIFO is non-empty (registered, evaluated each cycle).
  - init = 1 from IDLE or ACTIVE -> INIT. FIFO contents are retained; arbitration is frozen while in INIT.
  - idle = (state == IDLE).
- Ingress:
  - Word accepted into VC[class] when push_in & in_ready; accepted in every state except RST.
  - push_in & !in_ready: word dropped, error[0] set.
- Arbiter (IDLE/ACTIVE only):
  - eligible[i] = VC i non-empty & egress count[dest(head_i)] < thr_H.
  - RR: grant the first eligible index starting at rr_ptr; rr_ptr <= grant+1 mod NUM_CH. rr_ptr holds when nothing is granted.
  - Strict: grant the lowest eligible index; rr_ptr unchanged.
  - Grant pops the VC head and pushes it into egress[dest] on the same edge; at most one transfer per cycle.
  - Because thr_H <= DEPTH-1, egress never overflows.
  - Latency: push_in at edge e -> empty_out[dest] low after edge e+1 if uncontested.
- Egress:
  - pop_out[i] & !empty_out[i] advances the head and increments counter[i], which wraps at 2**CNT_W.
  - pop_out[i] on empty: ignored, error[1] set.
- Counter read:
  - In IDLE, req = 1 -> next cycle cnt_valid = 1 and cnt_data = counter[idx] (0 if idx >= NUM_CH).
  - Otherwise cnt_valid = 0 and cnt_data holds.
- error bits clear only on reset.
- Reset asserted mid-operation discards all data next edge.

Test Plan:
- Reset, init = 1 with umbral_L = 1, umbral_H = 6, then init = 0 -> idle = 1 after 2 clocks; all empty_out = 1.
- Push 12'hA55 (class 2, dest 2) -> empty_out[2] low 2 edges later; data_out ch2 = 12'hA55. Pop -> counter[2] = 1; req idx = 2 in IDLE -> cnt_data = 1, cnt_valid = 1.
- Load 4 words into each of VC0..VC3, all with distinct dests, arb_mode = 0 -> egress arrival order cycles VC0, 1, 2, 3, 0, ... Repeat with arb_mode = 1 -> VC0 drains fully first.
- Send 8 words to dest 1 with no pops and umbral_H = 6 -> egress1 holds 6 words and the VC keeps 2. Pop one -> one more transfers. No error.
- Push 9 words of class 0 while arbitration is blocked (init held) -> in_ready = 0 on the 9th push; error[0] = 1. Pop on empty egress -> error[1] = 1.
- Reset mid-traffic -> next cycle all empty_out = 1, counters 0, error 0, state RST.

Source files
------------

// File: rtl/pcie_switch_core_p.sv
// pcie_switch_core_p: parametrised VC-buffered switch core with a
// round-robin / strict arbiter, threshold FSM and egress pop counters.
module pcie_switch_core_p #(
  parameter int DATA_W     = 12,
  parameter int CH_LOG2    = 2,
  parameter int DEPTH_LOG2 = 3,
  parameter int THR_W      = 8,
  parameter int CNT_W      = 8,
  localparam int NUM_CH    = 2**CH_LOG2,
  localparam int CH_W      = CH_LOG2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [THR_W-1:0]         umbral_L,
  input  logic [THR_W-1:0]         umbral_H,
  input  logic                     arb_mode,
  input  logic                     push_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     in_ready,
  input  logic [NUM_CH-1:0]        pop_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        empty_out,
  output logic [NUM_CH-1:0]        almost_empty_out,
  output logic [NUM_CH-1:0]        almost_full_vc,
  input  logic                     req,
  input  logic [CH_W:0]            idx,
  output logic [CNT_W-1:0]         cnt_data,
  output logic                     cnt_valid,
  output logic                     idle,
  output logic [1:0]               error
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef enum logic [1:0] {RST, INIT, IDLE, ACTIVE} state_t;

  state_t          state;
  cnt_t            thr_l;
  cnt_t            thr_h;
  logic [CH_W-1:0] rr_ptr;

  word_t vc_mem [NUM_CH][DEPTH];
  ptr_t  vc_wp  [NUM_CH];
  ptr_t  vc_rp  [NUM_CH];
  cnt_t  vc_cnt [NUM_CH];
  word_t eg_mem [NUM_CH][DEPTH];
  ptr_t  eg_wp  [NUM_CH];
  ptr_t  eg_rp  [NUM_CH];
  cnt_t  eg_cnt [NUM_CH];

  logic [CNT_W-1:0] pop_cnt [NUM_CH];

  logic [NUM_CH-1:0] vc_ne;
  logic [NUM_CH-1:0] eg_ne;
  logic [NUM_CH-1:0] vc_push;
  logic [NUM_CH-1:0] vc_pop;
  logic [NUM_CH-1:0] eg_push;
  logic [NUM_CH-1:0] eg_pop;
  logic [NUM_CH-1:0] elig;

  word_t           vc_head [NUM_CH];
  logic [CH_W-1:0] vc_dst  [NUM_CH];
  logic [CH_W-1:0] in_cls;
  logic [CH_W-1:0] gnt;
  logic [CH_W-1:0] gnt_dst;
  logic [CH_W-1:0] scan;
  logic            gnt_vld;
  logic            arb_en;
  logic            accept;
  word_t           gnt_word;

  function automatic cnt_t clip(input logic [THR_W-1:0] u);
    if (u > THR_W'(DEPTH - 1)) return cnt_t'(DEPTH - 1);
    return cnt_t'(u);
  endfunction

  assign in_cls   = data_in[DATA_W-1 -: CH_W];
  assign in_ready = vc_cnt[in_cls] != cnt_t'(DEPTH);
  assign accept   = push_in && in_ready && state != RST;
  assign arb_en   = state == IDLE || state == ACTIVE;
  assign idle     = state == IDLE;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      vc_ne[i]   = vc_cnt[i] != '0;
      eg_ne[i]   = eg_cnt[i] != '0;
      vc_head[i] = vc_mem[i][vc_rp[i]];
      vc_dst[i]  = vc_head[i][DATA_W-1-CH_W -: CH_W];
      elig[i]    = arb_en && vc_ne[i] &&
                   eg_cnt[vc_dst[i]] < thr_h;
    end
  end

  // Scan from the far end so the closest eligible index wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    scan    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      scan = arb_mode ? CH_W'(k) : rr_ptr + CH_W'(k);
      if (elig[scan]) begin
        gnt_vld = 1'b1;
        gnt     = scan;
      end
    end
  end

  assign gnt_word = vc_head[gnt];
  assign gnt_dst  = vc_dst[gnt];

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      vc_push[i] = accept && in_cls == CH_W'(i);
      vc_pop[i]  = gnt_vld && gnt == CH_W'(i);
      eg_push[i] = gnt_vld && gnt_dst == CH_W'(i);
      eg_pop[i]  = pop_out[i] && eg_ne[i];
      data_out[i*DATA_W +: DATA_W] =
        eg_ne[i] ? eg_mem[i][eg_rp[i]] : '0;
      empty_out[i]        = !eg_ne[i];
      almost_empty_out[i] = eg_cnt[i] <= thr_l;
      almost_full_vc[i]   = vc_cnt[i] >= thr_h;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (vc_push[i]) vc_mem[i][vc_wp[i]] <= data_in;
      if (eg_push[i]) eg_mem[i][eg_wp[i]] <= gnt_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        vc_wp[i]   <= '0;
        vc_rp[i]   <= '0;
        vc_cnt[i]  <= '0;
        eg_wp[i]   <= '0;
        eg_rp[i]   <= '0;
        eg_cnt[i]  <= '0;
        pop_cnt[i] <= '0;
      end
      error <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (vc_push[i]) vc_wp[i] <= vc_wp[i] + ptr_t'(1);
        if (vc_pop[i])  vc_rp[i] <= vc_rp[i] + ptr_t'(1);
        vc_cnt[i] <= vc_cnt[i] + cnt_t'(vc_push[i])
                     - cnt_t'(vc_pop[i]);
        if (eg_push[i]) eg_wp[i] <= eg_wp[i] + ptr_t'(1);
        if (eg_pop[i])  eg_rp[i] <= eg_rp[i] + ptr_t'(1);
        eg_cnt[i] <= eg_cnt[i] + cnt_t'(eg_push[i])
                     - cnt_t'(eg_pop[i]);
        if (eg_pop[i])
          pop_cnt[i] <= pop_cnt[i] + (CNT_W)'(1);
      end
      if (push_in && !in_ready) error[0] <= 1'b1;
      if (|(pop_out & ~eg_ne))  error[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RST;
      thr_l     <= cnt_t'(1);
      thr_h     <= cnt_t'(DEPTH - 2);
      rr_ptr    <= '0;
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      if (state == IDLE && req) begin
        cnt_valid <= 1'b1;
        cnt_data  <= idx[CH_W] ? '0 : pop_cnt[idx[CH_W-1:0]];
      end
      if (gnt_vld && !arb_mode) rr_ptr <= gnt + CH_W'(1);
      unique case (state)
        RST: state <= INIT;
        INIT: begin
          thr_l <= clip(umbral_L);
          thr_h <= (clip(umbral_H) == '0) ? cnt_t'(1)
                                          : clip(umbral_H);
          if (!init) state <= IDLE;
        end
        IDLE, ACTIVE: begin
          if (init)                  state <= INIT;
          else if (|{vc_ne, eg_ne})  state <= ACTIVE;
          else                       state <= IDLE;
        end
        default: state <= RST;
      endcase
    end
  end

endmodule
